// File: rtl/layer_stream_sequencer.sv
// Host-side stream partner for one fully connected layer: buffers an N-word input vector,
// streams it out, collects M results. Optional cycle counter: define LAYER_SEQ_CYCLE_COUNT_EN.
module layer_stream_sequencer #(
  parameter int unsigned M    = 13,
  parameter int unsigned N    = 16,
  parameter int unsigned T    = 32,
  parameter int unsigned logN = $clog2(N + 1),
  parameter int unsigned logM = $clog2(M + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            host_wr_en,
  input  logic [logN-1:0] host_wr_addr,
  input  logic [T-1:0]    host_wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [logM-1:0] rd_addr,
  output logic [T-1:0]    rd_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [T-1:0]    m_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    s_data
`ifdef LAYER_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]     cycle_count
`endif
);

  localparam int unsigned NIdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MIdxW = (M > 1) ? $clog2(M) : 1;
  localparam logic [logN-1:0] NCnt  = logN'(N);
  localparam logic [logN-1:0] NLast = logN'(N - 1);
  localparam logic [logM-1:0] MCnt  = logM'(M);
  localparam logic [logM-1:0] MLast = logM'(M - 1);

  // StLoad is a one-cycle spacer so the first word appears two cycles after start.
  typedef enum logic [1:0] {StIdle, StLoad, StSend, StRecv} state_e;

  state_e          state_q, state_d;
  logic [T-1:0]    x_q   [N];
  logic [T-1:0]    res_q [M];
  logic [logN-1:0] send_idx_q, send_idx_d;
  logic [logM-1:0] recv_idx_q, recv_idx_d;
  logic            m_valid_q, m_valid_d;
  logic [T-1:0]    m_data_q, m_data_d;
  logic            done_q, done_d;
  logic [T-1:0]    rd_data_q;
  logic            start_ok, x_we, res_we;

  assign busy     = (state_q != StIdle);
  assign start_ok = (state_q == StIdle) && start;
  assign x_we     = host_wr_en && !busy && (host_wr_addr < NCnt) && !reset;
  assign res_we   = (state_q == StRecv) && s_valid && !reset;

  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign s_ready = (state_q == StRecv);
  assign rd_data = rd_data_q;

  always_comb begin
    state_d    = state_q;
    send_idx_d = send_idx_q;
    recv_idx_d = recv_idx_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    done_d     = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          done_d     = 1'b0;
          send_idx_d = '0;
          recv_idx_d = '0;
        end
      end
      StLoad: state_d = StSend;
      StSend: begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = x_q[send_idx_q[NIdxW-1:0]];
        end else if (m_ready) begin
          if (send_idx_q == NLast) begin
            m_valid_d = 1'b0;
            state_d   = StRecv;
          end else begin
            send_idx_d = send_idx_q + 1'b1;
            m_data_d   = x_q[send_idx_d[NIdxW-1:0]];
          end
        end
      end
      StRecv: begin
        if (s_valid) begin
          if (recv_idx_q == MLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            recv_idx_d = recv_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      send_idx_q <= '0;
      recv_idx_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      send_idx_q <= send_idx_d;
      recv_idx_q <= recv_idx_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      done_q     <= done_d;
    end
  end

  // Buffers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (x_we) begin
      x_q[host_wr_addr[NIdxW-1:0]] <= host_wr_data;
    end
    if (res_we) begin
      res_q[recv_idx_q[MIdxW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_addr < MCnt) begin
      rd_data_q <= res_q[rd_addr[MIdxW-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

`ifdef LAYER_SEQ_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
    end else if (start_ok) begin
      cyc_q <= '0;
    end else if (busy) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Directed bench for layer_stream_sequencer with a behavioural layer attached.
// The layer returns y[k] = sum(x) + k, so expected results are hand-computable constants.
module tb_layer_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_wr_en;
  logic [4:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
`ifdef LAYER_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  always #5 clk = ~clk;

  layer_stream_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data)
`ifdef LAYER_SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count  (cycle_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Layer model state; written only by the layer process.
  logic        layer_clr;
  logic        stall_mode;
  logic [31:0] sent_q [$];
  int          in_cnt, out_cnt, done_rises, busy_cyc, hold_seen, hold_bad;
  int          cyc, first_cyc, last_cyc;
  logic [31:0] sum, stall_data;
  logic        stalled, done_prev;
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  initial begin
    m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
    in_cnt = 0; out_cnt = 0; done_rises = 0; busy_cyc = 0; hold_seen = 0; hold_bad = 0;
    cyc = 0; first_cyc = 0; last_cyc = 0; sum = '0; stall_data = '0;
    stalled = 1'b0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (layer_clr) begin
        in_cnt = 0; out_cnt = 0; done_rises = 0; busy_cyc = 0; hold_seen = 0; hold_bad = 0;
        sum = '0; stalled = 1'b0;
        sent_q.delete();
      end
      if (stalled) begin
        hold_seen++;
        if (m_valid !== 1'b1 || m_data !== stall_data) hold_bad++;
      end
      m_ready = stall_mode ? pat[cyc % 6] : 1'b1;
      s_valid = (in_cnt == 16) && (out_cnt < 13);
      s_data  = sum + 32'(out_cnt);
      if (m_valid && m_ready) begin
        sent_q.push_back(m_data);
        sum = sum + m_data;
        if (in_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        in_cnt++;
      end
      stalled    = m_valid && !m_ready;
      stall_data = m_data;
      if (s_valid && s_ready) out_cnt++;
      if (done && !done_prev) done_rises++;
      done_prev = done;
      if (busy) busy_cyc++;
    end
  end

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic clear_layer();
    layer_clr = 1'b1;
    repeat (2) @(negedge clk);
    layer_clr = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("s_ready_at_done", 32'(s_ready), 32'd0);
    check_eq("results_taken", 32'(out_cnt), 32'd13);
  endtask

  task automatic check_sent(input logic [31:0] first);
    check_eq("sent_count", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < sent_q.size() && i < 16; i++) begin
      check_eq($sformatf("sent[%0d]", i), sent_q[i], (i == 0) ? first : 32'(i + 1));
    end
  endtask

  task automatic check_results(input logic [31:0] base);
    for (int k = 0; k < 13; k++) begin
      rd_addr = 4'(k);
      @(negedge clk);
      check_eq($sformatf("res[%0d]", k), rd_data, base + 32'(k));
    end
    rd_addr = 4'd13;
    @(negedge clk);
    check_eq("rd_oob13", rd_data, 32'd0);
    rd_addr = 4'd15;
    @(negedge clk);
    check_eq("rd_oob15", rd_data, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    rd_addr = 4'd13; layer_clr = 1'b1; stall_mode = 1'b0;

    // 1: reset state
    repeat (2) @(negedge clk);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_m_data", m_data, 32'd0);
    reset = 1'b0;

    // 2: full run with m_ready held high; sum(1..16) = 136
    for (int i = 0; i < 16; i++) host_write(5'(i), 32'(i + 1));
    clear_layer();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t2_busy_after_start", 32'(busy), 32'd1);
    check_eq("t2_m_valid_c1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check_eq("t2_m_valid_c2", 32'(m_valid), 32'd0);
    @(negedge clk);
    check_eq("t2_m_valid_c3", 32'(m_valid), 32'd1);
    check_eq("t2_m_data_first", m_data, 32'd1);
    wait_done();
    check_eq("t2_no_bubbles", 32'(last_cyc - first_cyc), 32'd15);
    check_eq("t2_busy_cycles", 32'(busy_cyc), 32'd31);
    check_sent(32'd1);
    check_results(32'd136);

    // 3: stalled sends
    clear_layer();
    stall_mode = 1'b1;
    start_pulse();
    wait_done();
    stall_mode = 1'b0;
    check_sent(32'd1);
    check_eq("t3_hold_seen", 32'(hold_seen > 0), 32'd1);
    check_eq("t3_hold_bad", 32'(hold_bad), 32'd0);
    check_results(32'd136);

    // 4: out-of-range write, then start + write during SEND are ignored
    host_write(5'd16, 32'hBEEF);
    clear_layer();
    start_pulse();
    repeat (4) @(negedge clk);
    start = 1'b1; host_wr_en = 1'b1; host_wr_addr = 5'd0; host_wr_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; host_wr_en = 1'b0;
    wait_done();
    check_sent(32'd1);
    check_results(32'd136);
    check_eq("t4_done_rises", 32'(done_rises), 32'd1);

    // 5: reset mid-send, then write+start together; sum = 136 - 1 + 0x55 = 220
    clear_layer();
    start_pulse();
    n = 0;
    while (in_cnt < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_reached_5", 32'(in_cnt >= 5), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t5_m_valid", 32'(m_valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_s_ready", 32'(s_ready), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    check_eq("t5_m_data", m_data, 32'd0);
    clear_layer();
    start = 1'b1; host_wr_en = 1'b1; host_wr_addr = 5'd0; host_wr_data = 32'h55;
    @(negedge clk);
    start = 1'b0; host_wr_en = 1'b0;
    wait_done();
    check_sent(32'h55);
    check_results(32'd220);

`ifdef LAYER_SEQ_CYCLE_COUNT_EN
    // 6: cycle counter spans start..done and then holds
    clear_layer();
    start_pulse();
    wait_done();
    check_eq("t6_cycle_count", cycle_count, 32'd31);
    check_eq("t6_busy_cycles", 32'(busy_cyc), 32'd31);
    repeat (5) @(negedge clk);
    check_eq("t6_cycle_hold", cycle_count, 32'd31);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
